// File: rtl/seq_log_pkg.sv
// Shared defaults and helpers for the sequence-hit logger.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package seq_log_pkg;

  localparam int TS_W_DEF  = 16;
  localparam int CNT_W_DEF = 16;
  localparam int DEPTH_DEF = 8;

  // Address width of a FIFO with the given number of entries.
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Increment v, holding at the all-ones value of a w-bit counter (w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? max_v : (v + 32'd1);
  endfunction

endpackage

// File: rtl/hit_fifo.sv
// First-word-fall-through FIFO of timestamps with occupancy output.
// Latency: a push is visible at the head immediately after its edge; pops expose the next head the same way.
// Backpressure: push refused only when full and no pop at the same edge (o_push_ok=0); i_flush wins over both.
module hit_fifo
  import seq_log_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [W-1:0]             i_push_dat,
  input  logic                     i_pop_rdy,
  output logic                     o_vld,
  output logic [W-1:0]             o_dat,
  output logic [ptr_w(DEPTH):0]    o_level,
  output logic                     o_push_ok
);

  localparam int AW = ptr_w(DEPTH);

  // Pointers carry one extra bit so a full FIFO and an empty FIFO differ.
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic [W-1:0] r_mem [DEPTH];

  logic [AW:0]  w_level;
  logic         w_empty;
  logic         w_full;
  logic         w_pop;
  logic         w_push;

  assign w_level   = r_wr_ptr - r_rd_ptr;
  assign w_empty   = (w_level == '0);
  assign w_full    = (w_level == (AW+1)'(DEPTH));
  assign w_pop     = !w_empty && i_pop_rdy;
  // When full, a same-edge pop frees the slot the write lands in.
  assign o_push_ok = !w_full || w_pop;
  assign w_push    = i_push && o_push_ok;

  assign o_vld   = !w_empty;
  assign o_dat   = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  assign o_level = w_level;

  // Advance pointers on accepted push/pop; flush empties the FIFO.
  always_ff @(posedge i_clk) begin
    if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge i_clk) begin
    if (w_push && !i_flush) r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
  end

endmodule

// File: rtl/seq_hit_logger.sv
// Timestamps detector hits with a free-running counter and queues them for the host.
// Latency: a hit at edge E shows up at the FIFO head right after E with the pre-E timestamp.
// Backpressure: host drains via rd_valid/rd_ready; hits arriving with no free slot are counted and dropped.
module seq_hit_logger
  import seq_log_pkg::*;
#(
  parameter int TS_W  = TS_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_hit,
  input  logic                     i_clear,
  input  logic                     i_rd_ready,
  output logic                     o_rd_valid,
  output logic [TS_W-1:0]          o_rd_data,
  output logic [ptr_w(DEPTH):0]    o_level,
  output logic [CNT_W-1:0]         o_hit_count,
  output logic [CNT_W-1:0]         o_drop_count,
  output logic                     o_overflow
);

  logic [TS_W-1:0]  r_ts;
  logic [CNT_W-1:0] r_hit_count;
  logic [CNT_W-1:0] r_drop_count;
  logic             r_overflow;

  logic             w_flush;
  logic             w_push_ok;
  logic             w_drop;
  logic [CNT_W-1:0] w_hit_nxt;
  logic [CNT_W-1:0] w_drop_nxt;

  // Reset and clear both empty the queue; a same-edge hit or pop is discarded.
  assign w_flush    = i_reset || i_clear;
  assign w_drop     = i_hit && !w_push_ok;
  assign w_hit_nxt  = CNT_W'(sat_inc(32'(r_hit_count), CNT_W));
  assign w_drop_nxt = CNT_W'(sat_inc(32'(r_drop_count), CNT_W));

  hit_fifo #(
    .W     (TS_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk      (i_clk),
    .i_flush    (w_flush),
    .i_push     (i_hit),
    .i_push_dat (r_ts),
    .i_pop_rdy  (i_rd_ready),
    .o_vld      (o_rd_valid),
    .o_dat      (o_rd_data),
    .o_level    (o_level),
    .o_push_ok  (w_push_ok)
  );

  // Free-running timestamp; only reset restarts it, clear leaves it running.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_ts <= '0;
    else         r_ts <= r_ts + TS_W'(1);
  end

  // Saturating hit/drop counters and sticky overflow, zeroed by reset or clear.
  always_ff @(posedge i_clk) begin
    if (w_flush) begin
      r_hit_count  <= '0;
      r_drop_count <= '0;
      r_overflow   <= 1'b0;
    end else begin
      if (i_hit) r_hit_count <= w_hit_nxt;
      if (w_drop) begin
        r_drop_count <= w_drop_nxt;
        r_overflow   <= 1'b1;
      end
    end
  end

  assign o_hit_count  = r_hit_count;
  assign o_drop_count = r_drop_count;
  assign o_overflow   = r_overflow;

endmodule

// File: tb/tb_seq_hit_logger.sv
module tb_seq_hit_logger;

  logic        clk;
  logic        reset;
  logic        hit;
  logic        clear;
  logic        rd_ready;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic [3:0]  level;
  logic [15:0] hit_count;
  logic [15:0] drop_count;
  logic        overflow;

  // Narrow instance for wrap and saturation.
  logic        s_hit;
  logic        s_clear;
  logic        s_rd_ready;
  logic        s_rd_valid;
  logic [3:0]  s_rd_data;
  logic [3:0]  s_level;
  logic [2:0]  s_hit_count;
  logic [2:0]  s_drop_count;
  logic        s_overflow;

  int          errors = 0;
  int          checks = 0;
  int          m_ts   = 0;
  logic [15:0] exp_q[$];
  logic [3:0]  exp_q2[$];
  logic [15:0] mon_e;
  logic [3:0]  mon_e2;
  logic [6:0]  bits;
  logic [2:0]  hist;
  logic        d;

  seq_hit_logger u_dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_hit        (hit),
    .i_clear      (clear),
    .i_rd_ready   (rd_ready),
    .o_rd_valid   (rd_valid),
    .o_rd_data    (rd_data),
    .o_level      (level),
    .o_hit_count  (hit_count),
    .o_drop_count (drop_count),
    .o_overflow   (overflow)
  );

  seq_hit_logger #(.TS_W(4), .CNT_W(3), .DEPTH(8)) u_small (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_hit        (s_hit),
    .i_clear      (s_clear),
    .i_rd_ready   (s_rd_ready),
    .o_rd_valid   (s_rd_valid),
    .o_rd_data    (s_rd_data),
    .o_level      (s_level),
    .o_hit_count  (s_hit_count),
    .o_drop_count (s_drop_count),
    .o_overflow   (s_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d", name, act, exp);
    end
  endtask

  // One clock; tracks the timestamp the DUT should hold after the edge.
  task automatic step();
    @(posedge clk);
    if (reset) m_ts = 0;
    else       m_ts = m_ts + 1;
    #1;
  endtask

  task automatic drain();
    rd_ready = 1'b1;
    for (int k = 0; k < 20 && rd_valid; k++) step();
    rd_ready = 1'b0;
    chk("drain_done", 32'(rd_valid), 0);
  endtask

  // Scoreboard monitor, main instance: compare the head at every pop.
  always @(negedge clk) begin
    if (!reset && !clear && rd_valid && rd_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected got=%0d required=none", rd_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (rd_data !== mon_e) begin
          errors++;
          $display("FAIL pop_data got=%0d required=%0d", rd_data, mon_e);
        end
      end
    end
  end

  // Scoreboard monitor, narrow instance.
  always @(negedge clk) begin
    if (!reset && !s_clear && s_rd_valid && s_rd_ready) begin
      checks++;
      if (exp_q2.size() == 0) begin
        errors++;
        $display("FAIL s_pop_unexpected got=%0d required=none", s_rd_data);
      end else begin
        mon_e2 = exp_q2.pop_front();
        if (s_rd_data !== mon_e2) begin
          errors++;
          $display("FAIL s_pop_data got=%0d required=%0d", s_rd_data, mon_e2);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; hit = 1'b0; clear = 1'b0; rd_ready = 1'b0;
    s_hit = 1'b0; s_clear = 1'b0; s_rd_ready = 1'b1;
    step(); step();
    reset = 1'b0;

    // Reset values
    chk("rst_valid", 32'(rd_valid), 0);
    chk("rst_data", 32'(rd_data), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_hits", 32'(hit_count), 0);
    chk("rst_drops", 32'(drop_count), 0);
    chk("rst_ovf", 32'(overflow), 0);

    // Single hit at ts=5
    while (m_ts != 5) step();
    hit = 1'b1; exp_q.push_back(16'd5);
    step();
    hit = 1'b0;
    chk("single_valid", 32'(rd_valid), 1);
    chk("single_data", 32'(rd_data), 5);
    chk("single_level", 32'(level), 1);
    chk("single_hits", 32'(hit_count), 1);
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    chk("single_pop_valid", 32'(rd_valid), 0);
    chk("single_pop_level", 32'(level), 0);
    chk("single_pop_data", 32'(rd_data), 0);

    // Detector chain: 0110110 through a Mealy 0110 detector
    bits = 7'b0110110;
    hist = 3'b000;
    for (int i = 6; i >= 0; i--) begin
      d = (hist == 3'b011) && !bits[i];
      hist = {hist[1:0], bits[i]};
      hit = d;
      if (d) exp_q.push_back(16'(m_ts));
      step();
    end
    hit = 1'b0;
    chk("chain_level", 32'(level), 2);
    chk("chain_hits", 32'(hit_count), 3);
    drain();

    // Plain clear
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_hits", 32'(hit_count), 0);
    chk("clr_ovf", 32'(overflow), 0);

    // Overflow: 10 hits into 8 slots, no reads
    for (int i = 0; i < 10; i++) begin
      hit = 1'b1;
      if (i < 8) exp_q.push_back(16'(m_ts));
      step();
    end
    hit = 1'b0;
    chk("ovf_level", 32'(level), 8);
    chk("ovf_hits", 32'(hit_count), 10);
    chk("ovf_drops", 32'(drop_count), 2);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_valid", 32'(rd_valid), 1);

    // Push on full with simultaneous pop
    hit = 1'b1; rd_ready = 1'b1; exp_q.push_back(16'(m_ts));
    step();
    hit = 1'b0; rd_ready = 1'b0;
    chk("pof_level", 32'(level), 8);
    chk("pof_drops", 32'(drop_count), 2);
    chk("pof_hits", 32'(hit_count), 11);
    drain();
    chk("pof_sticky", 32'(overflow), 1);
    chk("pof_empty", 32'(level), 0);

    // Clear priority over hit and pop
    for (int i = 0; i < 3; i++) begin
      hit = 1'b1; exp_q.push_back(16'(m_ts));
      step();
    end
    hit = 1'b0;
    chk("cp_level3", 32'(level), 3);
    clear = 1'b1; hit = 1'b1; rd_ready = 1'b1;
    step();
    clear = 1'b0; hit = 1'b0; rd_ready = 1'b0;
    exp_q.delete();
    chk("cp_level", 32'(level), 0);
    chk("cp_hits", 32'(hit_count), 0);
    chk("cp_drops", 32'(drop_count), 0);
    chk("cp_ovf", 32'(overflow), 0);
    chk("cp_valid", 32'(rd_valid), 0);
    // Timestamp must continue uninterrupted across clear
    hit = 1'b1; exp_q.push_back(16'(m_ts));
    step();
    hit = 1'b0;
    chk("cp_ts_level", 32'(level), 1);
    drain();

    // Wrap and saturation on the narrow instance
    for (int i = 0; i < 20; i++) begin
      s_hit = 1'b1; exp_q2.push_back(4'(m_ts));
      step();
    end
    s_hit = 1'b0;
    step();
    chk("wrap_hits_sat", 32'(s_hit_count), 7);
    chk("wrap_drops", 32'(s_drop_count), 0);
    chk("wrap_level", 32'(s_level), 0);

    step();
    chk("q_main_empty", 32'(exp_q.size()), 0);
    chk("q_small_empty", 32'(exp_q2.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
